// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I control FSM and its datapath/memory port.
// master = control FSM side, slave = datapath side.
interface multicycle_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [6:0]       opcode;
   logic             branch_taken;
   logic             mem_ready;
   logic             pc_we;
   logic             ir_we;
   logic             we;
   logic             mem_req;
   logic             mem_we;
   logic             addr_src;
   logic [1:0]       alu_op;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       result_src;
   logic             pc_src;
   logic             trap;
   logic [3:0]       state_dbg;
   logic [CNT_W-1:0] instret;

   modport master (
      input  opcode, branch_taken, mem_ready,
      output pc_we, ir_we, we, mem_req, mem_we, addr_src, alu_op, alu_src_a, alu_src_b,
             result_src, pc_src, trap, state_dbg, instret
   );

   modport slave (
      output opcode, branch_taken, mem_ready,
      input  pc_we, ir_we, we, mem_req, mem_we, addr_src, alu_op, alu_src_a, alu_src_b,
             result_src, pc_src, trap, state_dbg, instret
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/writeback,
// stalls on the memory handshake, counts retired instructions and latches illegal opcodes.
module multicycle_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   multicycle_ctrl_if.master   bus
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAddr = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecR   = 4'd6,
      StExecI   = 4'd7,
      StWbAlu   = 4'd8,
      StBranch  = 4'd9,
      StJal     = 4'd10,
      StJalr    = 4'd11,
      StLui     = 4'd12,
      StTrap    = 4'd15
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             trap_q, trap_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:   if (bus.mem_ready) state_d = StDecode;
         StDecode: begin
            case (bus.opcode)
               OpLoad, OpStore: state_d = StMemAddr;
               OpReg:           state_d = StExecR;
               OpImm:           state_d = StExecI;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalr;
               OpLui:           state_d = StLui;
               OpAuipc:         state_d = StWbAlu;
               default:         state_d = StTrap;
            endcase
         end
         StMemAddr: state_d = (bus.opcode == OpLoad) ? StMemRd : StMemWr;
         StMemRd:   if (bus.mem_ready) state_d = StMemWb;
         StMemWb:   state_d = StFetch;
         StMemWr:   if (bus.mem_ready) state_d = StFetch;
         StExecR:   state_d = StWbAlu;
         StExecI:   state_d = StWbAlu;
         StLui:     state_d = StWbAlu;
         StWbAlu:   state_d = StFetch;
         StBranch:  state_d = StFetch;
         StJalr:    state_d = StJal;
         StJal:     state_d = StFetch;
         StTrap:    state_d = StTrap;
         default:   state_d = StFetch;
      endcase
   end

   // An instruction retires on the cycle it hands control back to fetch.
   always_comb begin
      instret_d = instret_q;
      if (state_q != StFetch && state_d == StFetch) begin
         instret_d = instret_q + CNT_W'(1);
      end
      trap_d = (state_d == StTrap);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         instret_q <= '0;
         trap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
         trap_q    <= trap_d;
      end
   end

   always_comb begin
      bus.pc_we      = 1'b0;
      bus.ir_we      = 1'b0;
      bus.we         = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.addr_src   = 1'b0;
      bus.alu_op     = 2'b00;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.result_src = 2'b00;
      bus.pc_src     = 1'b0;
      case (state_q)
         StFetch: begin
            bus.mem_req    = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            bus.pc_we      = bus.mem_ready;
            bus.ir_we      = bus.mem_ready;
         end
         StDecode: begin
            bus.alu_src_a = 2'b01;
            bus.alu_src_b = 2'b01;
         end
         StMemAddr: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
         end
         StMemRd: begin
            bus.mem_req  = 1'b1;
            bus.addr_src = 1'b1;
         end
         StMemWb: begin
            bus.we         = 1'b1;
            bus.result_src = 2'b01;
         end
         StMemWr: begin
            bus.mem_req  = 1'b1;
            bus.mem_we   = 1'b1;
            bus.addr_src = 1'b1;
         end
         StExecR: begin
            bus.alu_src_a = 2'b10;
            bus.alu_op    = 2'b10;
         end
         StExecI: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
            bus.alu_op    = 2'b10;
         end
         StLui: begin
            bus.alu_src_a = 2'b11;
            bus.alu_src_b = 2'b01;
         end
         StWbAlu: bus.we = 1'b1;
         StBranch: begin
            bus.alu_src_a = 2'b10;
            bus.alu_op    = 2'b01;
            bus.pc_src    = 1'b1;
            bus.pc_we     = bus.branch_taken;
         end
         StJalr: begin
            bus.alu_src_a = 2'b10;
            bus.alu_src_b = 2'b01;
         end
         StJal: begin
            bus.alu_src_a  = 2'b01;
            bus.alu_src_b  = 2'b10;
            bus.result_src = 2'b10;
            bus.we         = 1'b1;
            bus.pc_src     = 1'b1;
            bus.pc_we      = 1'b1;
         end
         default: ;
      endcase
      // Reset squashes every side effect combinationally, including a pending access.
      if (reset) begin
         bus.pc_we   = 1'b0;
         bus.ir_we   = 1'b0;
         bus.we      = 1'b0;
         bus.mem_req = 1'b0;
         bus.mem_we  = 1'b0;
      end
   end

   assign bus.trap      = trap_q & ~reset;
   assign bus.state_dbg = state_q;
   assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model with random
// memory wait states, plus a narrow-counter instance to observe instret wraparound.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;

   int          checks;
   int          errors;
   int unsigned model_cnt;

   multicycle_ctrl_if #(.CNT_W(32)) ifa ();
   multicycle_ctrl_if #(.CNT_W(3))  ifw ();

   assign ifa.opcode       = opcode;
   assign ifa.branch_taken = branch_taken;
   assign ifa.mem_ready    = mem_ready;
   assign ifw.opcode       = opcode;
   assign ifw.branch_taken = branch_taken;
   assign ifw.mem_ready    = mem_ready;

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.master)
   );

   multicycle_ctrl #(.CNT_W(3)) dut_w (
      .clk   (clk),
      .reset (reset),
      .bus   (ifw.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         mem_ready = 1'($urandom);
         opcode    = 7'($urandom);
         #4;
         chk("rst_mem_req", ifa.mem_req, 0);
         chk("rst_enables", {ifa.pc_we, ifa.ir_we, ifa.we, ifa.mem_we}, 0);
         chk("rst_trap", ifa.trap, 0);
         next_cycle();
      end
      reset     = 1'b0;
      model_cnt = 0;
      chk("post_rst_state", ifa.state_dbg, 0);
      chk("post_rst_instret", ifa.instret, 0);
      chk("post_rst_instret_w", ifw.instret, 0);
      chk("post_rst_trap", ifa.trap, 0);
   endtask

   // Expected state walk is built from the instruction class; side effects are checked
   // against instruction-level rules (write at retirement, fetch strobes, memory bus use).
   task automatic run_instr(input logic [6:0] op, input bit bt, input int fw, input int mw);
      logic [3:0] st[$];
      bit         rdy[$];
      bit         writes;
      bit         pc_upd;
      bit         last;
      bit         is_mem;
      writes = 1'b1;
      pc_upd = 1'b0;
      for (int k = 0; k < fw; k++) begin st.push_back(4'd0); rdy.push_back(1'b0); end
      st.push_back(4'd0); rdy.push_back(1'b1);
      st.push_back(4'd1); rdy.push_back(1'($urandom));
      case (op)
         OP_LOAD: begin
            st.push_back(4'd2); rdy.push_back(1'($urandom));
            for (int k = 0; k < mw; k++) begin st.push_back(4'd3); rdy.push_back(1'b0); end
            st.push_back(4'd3); rdy.push_back(1'b1);
            st.push_back(4'd4); rdy.push_back(1'($urandom));
         end
         OP_STORE: begin
            writes = 1'b0;
            st.push_back(4'd2); rdy.push_back(1'($urandom));
            for (int k = 0; k < mw; k++) begin st.push_back(4'd5); rdy.push_back(1'b0); end
            st.push_back(4'd5); rdy.push_back(1'b1);
         end
         OP_R:     begin st.push_back(4'd6);  st.push_back(4'd8); end
         OP_I:     begin st.push_back(4'd7);  st.push_back(4'd8); end
         OP_LUI:   begin st.push_back(4'd12); st.push_back(4'd8); end
         OP_AUIPC: st.push_back(4'd8);
         OP_BR:    begin st.push_back(4'd9); writes = 1'b0; pc_upd = bt; end
         OP_JAL:   begin st.push_back(4'd10); pc_upd = 1'b1; end
         OP_JALR:  begin st.push_back(4'd11); st.push_back(4'd10); pc_upd = 1'b1; end
         default:  ;
      endcase
      while (rdy.size() < st.size()) rdy.push_back(1'($urandom));
      for (int i = 0; i < st.size(); i++) begin
         last         = (i == st.size() - 1);
         is_mem       = (st[i] == 4'd0) || (st[i] == 4'd3) || (st[i] == 4'd5);
         opcode       = (st[i] == 4'd0) ? 7'($urandom) : op;
         branch_taken = (st[i] == 4'd9) ? bt : 1'($urandom);
         mem_ready    = rdy[i];
         #4;
         chk("state", ifa.state_dbg, st[i]);
         chk("we", ifa.we, last && writes);
         chk("pc_we", ifa.pc_we, (st[i] == 4'd0 && rdy[i]) || (last && pc_upd));
         chk("ir_we", ifa.ir_we, st[i] == 4'd0 && rdy[i]);
         chk("mem_req", ifa.mem_req, is_mem);
         chk("mem_we", ifa.mem_we, st[i] == 4'd5);
         if (is_mem) chk("addr_src", ifa.addr_src, st[i] != 4'd0);
         if (st[i] == 4'd10) begin
            chk("jal_result_src", ifa.result_src, 2);
            chk("jal_pc_src", ifa.pc_src, 1);
         end
         if (st[i] == 4'd4) chk("memwb_result_src", ifa.result_src, 1);
         if (st[i] == 4'd9) chk("br_pc_src", ifa.pc_src, 1);
         chk("trap_idle", ifa.trap, 0);
         next_cycle();
      end
      model_cnt++;
      chk("end_state", ifa.state_dbg, 0);
      chk("instret", ifa.instret, model_cnt);
      chk("instret_w", ifw.instret, model_cnt % 8);
   endtask

   task automatic run_trap(input logic [6:0] op);
      mem_ready = 1'b1;
      opcode    = 7'($urandom);
      #4;
      chk("trap_fetch", ifa.state_dbg, 0);
      next_cycle();
      opcode = op;
      #4;
      chk("trap_decode", ifa.state_dbg, 1);
      chk("trap_decode_flag", ifa.trap, 0);
      next_cycle();
      for (int i = 0; i < 20; i++) begin
         mem_ready    = 1'($urandom);
         opcode       = 7'($urandom);
         branch_taken = 1'($urandom);
         #4;
         chk("trap_state", ifa.state_dbg, 15);
         chk("trap_flag", ifa.trap, 1);
         chk("trap_enables", {ifa.pc_we, ifa.ir_we, ifa.we, ifa.mem_req, ifa.mem_we}, 0);
         chk("trap_instret", ifa.instret, model_cnt);
         next_cycle();
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI,
                        OP_AUIPC};
   endfunction

   initial begin
      logic [6:0] ops[9];
      logic [6:0] bad;
      ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      checks       = 0;
      errors       = 0;
      model_cnt    = 0;
      opcode       = '0;
      branch_taken = 1'b0;
      mem_ready    = 1'b0;
      do_reset(2);

      run_instr(OP_R, 1'b0, 0, 0);
      run_instr(OP_LOAD, 1'b0, 0, 3);
      run_instr(OP_BR, 1'b1, 0, 0);
      run_instr(OP_BR, 1'b0, 0, 0);
      run_instr(OP_JALR, 1'b0, 0, 0);
      run_instr(OP_STORE, 1'b0, 2, 2);

      run_trap(7'h7F);
      do_reset(1);

      for (int n = 0; n < 40; n++) begin
         run_instr(ops[$urandom_range(8, 0)], 1'($urandom), int'($urandom_range(2, 0)),
                   int'($urandom_range(3, 0)));
      end

      do begin
         bad = 7'($urandom);
      end while (is_legal(bad));
      run_trap(bad);
      do_reset(1);

      // Reset while fetch is still waiting for memory abandons the access.
      run_instr(OP_I, 1'b0, 1, 0);
      mem_ready = 1'b0;
      opcode    = 7'($urandom);
      #4;
      chk("fetch_wait_req", ifa.mem_req, 1);
      next_cycle();
      do_reset(2);
      run_instr(OP_LUI, 1'b0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
